// File: rtl/key_matrix_scanner.sv
// ---------------------------------------------------------------------------
// key_matrix_scanner
//
// Scans a ROWS x COLS push-button matrix one row at a time (row driven low,
// columns sensed through external pull-ups) and debounces every key on its
// own counter. Debounced key state is presented row-major, bit r*COLS+c,
// matching the LED matrix driver's image layout. Every change of a debounced
// bit is also reported as a one-cycle event.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   row_n          out  [ROWS]        row drive, active low, at most one low
//   col_n          in   [COLS]        column sense, low = pressed, async
//   keys           out  [ROWS*COLS]   debounced state, 1 = pressed
//   key_event      out                one-cycle pulse on a keys bit change
//   event_idx      out  [IDX_W]       index of the changed key
//   event_pressed  out                new value of that key
//   scan_done      out                one-cycle pulse at the end of a frame
// ---------------------------------------------------------------------------
module key_matrix_scanner #(
    parameter int ROWS           = 6,
    parameter int COLS           = 6,
    parameter int SETTLE_CYCLES  = 1200,
    parameter int DEBOUNCE_SCANS = 8,
    localparam int NKEYS         = ROWS * COLS,
    localparam int IDX_W         = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ROWS-1:0]       row_n,
    input  logic [COLS-1:0]       col_n,
    output logic [NKEYS-1:0]      keys,
    output logic                  key_event,
    output logic [IDX_W-1:0]      event_idx,
    output logic                  event_pressed,
    output logic                  scan_done
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_PROC  = 2'd3;

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [RW-1:0]    ROW_LAST    = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);

    // ------------------------------------------------------------------
    // Column synchronizer. Its two-cycle latency falls inside the settle
    // window, so the snapshot always reflects the row currently driven.
    // ------------------------------------------------------------------
    logic [COLS-1:0] col_meta_q;
    logic [COLS-1:0] col_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Scan and debounce state
    // ------------------------------------------------------------------
    logic [1:0]                  state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic [COLS-1:0]             col_snap_q, col_snap_d;
    logic [ROWS-1:0]             row_n_q, row_n_d;
    logic [NKEYS-1:0]            keys_q, keys_d;
    logic [NKEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        key_event_q, key_event_d;
    logic [IDX_W-1:0]            event_idx_q, event_idx_d;
    logic                        event_pressed_q, event_pressed_d;
    logic                        scan_done_q, scan_done_d;

    // Key handled in the current PROC cycle.
    logic [IDX_W-1:0] k_idx;

    always_comb begin
        k_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    end

    // Sequencer: IDLE -> DRIVE -> LATCH -> PROC x COLS -> DRIVE(next row)
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        settle_d    = settle_q;
        col_snap_d  = col_snap_q;
        row_n_d     = row_n_q;
        scan_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d  = S_DRIVE;
                row_d    = '0;
                settle_d = '0;
                row_n_d  = ~ROWS'(1);
            end

            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_LATCH;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end

            S_LATCH: begin
                col_snap_d = ~col_sync_q;
                col_d      = '0;
                state_d    = S_PROC;
            end

            S_PROC: begin
                if (col_q == COL_LAST) begin
                    state_d  = S_DRIVE;
                    settle_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d       = '0;
                        scan_done_d = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                    // Only transition where the row drive moves.
                    row_n_d = ~(ROWS'(1) << row_d);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                row_n_d = '1;
            end
        endcase
    end

    // Debounce: one key per PROC cycle, so at most one event per cycle.
    always_comb begin
        keys_d          = keys_q;
        cnt_d           = cnt_q;
        key_event_d     = 1'b0;
        event_idx_d     = event_idx_q;
        event_pressed_d = event_pressed_q;

        if (state_q == S_PROC) begin
            if (col_snap_q[col_q] == keys_q[k_idx]) begin
                // Agreement clears any partial run, so short glitches die here.
                cnt_d[k_idx] = '0;
            end else if (cnt_q[k_idx] == CNT_LAST) begin
                keys_d[k_idx]   = ~keys_q[k_idx];
                cnt_d[k_idx]    = '0;
                key_event_d     = 1'b1;
                event_idx_d     = k_idx;
                event_pressed_d = ~keys_q[k_idx];
            end else begin
                cnt_d[k_idx] = cnt_q[k_idx] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            row_q           <= '0;
            col_q           <= '0;
            settle_q        <= '0;
            col_snap_q      <= '0;
            row_n_q         <= '1;
            keys_q          <= '0;
            cnt_q           <= '0;
            key_event_q     <= 1'b0;
            event_idx_q     <= '0;
            event_pressed_q <= 1'b0;
            scan_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            settle_q        <= settle_d;
            col_snap_q      <= col_snap_d;
            row_n_q         <= row_n_d;
            keys_q          <= keys_d;
            cnt_q           <= cnt_d;
            key_event_q     <= key_event_d;
            event_idx_q     <= event_idx_d;
            event_pressed_q <= event_pressed_d;
            scan_done_q     <= scan_done_d;
        end
    end

    assign row_n         = row_n_q;
    assign keys          = keys_q;
    assign key_event     = key_event_q;
    assign event_idx     = event_idx_q;
    assign event_pressed = event_pressed_q;
    assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_key_matrix_scanner
//
// Directed bench for key_matrix_scanner with ROWS=6, COLS=6, SETTLE_CYCLES=4,
// DEBOUNCE_SCANS=2 (row period 11, frame 66). Timing is measured in clock
// edges from the IDLE->DRIVE edge (phase 0). Key (r,c) is processed on the
// edge at phase 11*r + 6 + c of each frame.
// ---------------------------------------------------------------------------
module tb_key_matrix_scanner;

    localparam int ROWS = 6;
    localparam int COLS = 6;
    localparam int RP   = 11;
    localparam int FR   = 66;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  row_n;
    logic [5:0]  col_n;
    logic [35:0] keys;
    logic        key_event;
    logic [5:0]  event_idx;
    logic        event_pressed;
    logic        scan_done;
    logic [35:0] sw = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int ev_count    = 0;

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .keys(keys),
        .key_event(key_event), .event_idx(event_idx),
        .event_pressed(event_pressed), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (key_event === 1'b1) ev_count <= ev_count + 1;

    // Matrix model: a closed switch pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (row_n[r] === 1'b0 && sw[r*COLS+c]) col_n[c] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int phase();
        return (cyc - t0) % FR;
    endfunction

    task automatic wait_phase(input int p);
        int g = 0;
        while (phase() != p && g < FR + 2) begin
            tick();
            g++;
        end
        vectors++;
        if (phase() != p) begin
            miscompares++;
            $display("FAIL wait_phase: reached phase %0d, required %0d", phase(), p);
        end
    endtask

    task automatic test_reset();
        logic [5:0] er;
        rst = 1'b1;
        repeat (5) begin
            tick();
            vectors++;
            if (row_n !== 6'b111111) begin
                miscompares++;
                $display("FAIL reset_row_n: got %b want 111111", row_n);
            end
            vectors++;
            if ({keys, key_event, event_idx, event_pressed, scan_done} !== 45'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: keys=%h ev=%b idx=%0d pr=%b sd=%b want all 0",
                         keys, key_event, event_idx, event_pressed, scan_done);
            end
        end
        rst = 1'b0;
        tick();
        t0 = cyc;
        vectors++;
        if (row_n !== 6'b111110) begin
            miscompares++;
            $display("FAIL release_row_n: got %b want 111110", row_n);
        end
        for (int n = 1; n <= 2 * FR; n++) begin
            tick();
            er = ~(6'd1 << ((n / RP) % ROWS));
            vectors++;
            if (row_n !== er) begin
                miscompares++;
                $display("FAIL row_step n=%0d: got %b want %b", n, row_n, er);
            end
            vectors++;
            if (scan_done !== (n % FR == 0)) begin
                miscompares++;
                $display("FAIL scan_done n=%0d: got %b want %b", n, scan_done, (n % FR == 0));
            end
        end
        vectors++;
        if (ev_count != 0) begin
            miscompares++;
            $display("FAIL idle_events: got %0d want 0", ev_count);
        end
    endtask

    task automatic test_bounce();
        int base;
        wait_phase(0);
        base = ev_count;
        sw[15] = 1'b1;
        repeat (FR) tick();
        sw[15] = 1'b0;
        repeat (3 * FR) tick();
        vectors++;
        if (keys !== 36'd0) begin
            miscompares++;
            $display("FAIL bounce_keys: got %h want 0", keys);
        end
        vectors++;
        if (ev_count != base) begin
            miscompares++;
            $display("FAIL bounce_events: got %0d want %0d", ev_count - base, 0);
        end
    endtask

    task automatic test_press();
        int base;
        wait_phase(0);
        base = ev_count;
        sw[15] = 1'b1;
        repeat (96) tick();
        vectors++;
        if (keys !== 36'd0) begin
            miscompares++;
            $display("FAIL press_early: got %h want 0", keys);
        end
        tick();
        vectors++;
        if ({keys, key_event, event_idx, event_pressed} !== {36'h8000, 1'b1, 6'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL press_event: keys=%h ev=%b idx=%0d pr=%b want 8000 1 15 1",
                     keys, key_event, event_idx, event_pressed);
        end
        tick();
        vectors++;
        if (key_event !== 1'b0 || keys !== 36'h8000) begin
            miscompares++;
            $display("FAIL press_pulse: ev=%b keys=%h want 0 8000", key_event, keys);
        end
        repeat (2 * FR) tick();
        vectors++;
        if (ev_count != base + 1) begin
            miscompares++;
            $display("FAIL press_count: got %0d want 1", ev_count - base);
        end
    endtask

    task automatic test_release();
        int base;
        wait_phase(0);
        base = ev_count;
        sw[15] = 1'b0;
        repeat (96) tick();
        vectors++;
        if (keys !== 36'h8000) begin
            miscompares++;
            $display("FAIL release_early: got %h want 8000", keys);
        end
        tick();
        vectors++;
        if ({keys, key_event, event_idx, event_pressed} !== {36'h0, 1'b1, 6'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL release_event: keys=%h ev=%b idx=%0d pr=%b want 0 1 15 0",
                     keys, key_event, event_idx, event_pressed);
        end
        repeat (FR) tick();
        vectors++;
        if (ev_count != base + 1) begin
            miscompares++;
            $display("FAIL release_count: got %0d want 1", ev_count - base);
        end
    endtask

    task automatic test_same_row();
        int base;
        wait_phase(0);
        base = ev_count;
        sw[6]  = 1'b1;
        sw[11] = 1'b1;
        repeat (83) tick();
        vectors++;
        if ({keys, key_event, event_idx, event_pressed} !== {36'h40, 1'b1, 6'd6, 1'b1}) begin
            miscompares++;
            $display("FAIL row_first: keys=%h ev=%b idx=%0d pr=%b want 40 1 6 1",
                     keys, key_event, event_idx, event_pressed);
        end
        tick();
        vectors++;
        if (key_event !== 1'b0) begin
            miscompares++;
            $display("FAIL row_gap: got %b want 0", key_event);
        end
        repeat (4) tick();
        vectors++;
        if ({keys, key_event, event_idx, event_pressed} !== {36'h840, 1'b1, 6'd11, 1'b1}) begin
            miscompares++;
            $display("FAIL row_second: keys=%h ev=%b idx=%0d pr=%b want 840 1 11 1",
                     keys, key_event, event_idx, event_pressed);
        end
        repeat (FR) tick();
        vectors++;
        if (ev_count != base + 2) begin
            miscompares++;
            $display("FAIL row_count: got %0d want 2", ev_count - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        wait_phase(7);
        base = ev_count;
        rst = 1'b1;
        #1;
        vectors++;
        if ({keys, row_n, key_event, scan_done} !== {36'h0, 6'b111111, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_now: keys=%h row_n=%b ev=%b sd=%b want 0 111111 0 0",
                     keys, row_n, key_event, scan_done);
        end
        tick();
        tick();
        vectors++;
        if (ev_count != base || keys !== 36'h0) begin
            miscompares++;
            $display("FAIL midrst_hold: events=%0d keys=%h want 0 0", ev_count - base, keys);
        end
        rst = 1'b0;
        tick();
        t0 = cyc;
        vectors++;
        if (row_n !== 6'b111110) begin
            miscompares++;
            $display("FAIL midrst_release: got %b want 111110", row_n);
        end
        repeat (82) tick();
        vectors++;
        if (keys !== 36'h0 || ev_count != base) begin
            miscompares++;
            $display("FAIL midrst_early: keys=%h events=%0d want 0 0", keys, ev_count - base);
        end
        tick();
        vectors++;
        if ({key_event, event_idx, event_pressed} !== {1'b1, 6'd6, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_first: ev=%b idx=%0d pr=%b want 1 6 1",
                     key_event, event_idx, event_pressed);
        end
        repeat (5) tick();
        vectors++;
        if ({keys, key_event, event_idx, event_pressed} !== {36'h840, 1'b1, 6'd11, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_second: keys=%h ev=%b idx=%0d pr=%b want 840 1 11 1",
                     keys, key_event, event_idx, event_pressed);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press();
        test_release();
        test_same_row();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
